// File: rtl/tx_frame_sched.sv
// Frame scheduler: pilot request, zero-latency AXI-stream pass-through, then a guard gap.
// Optional pilot watchdog is built in with `define TX_FRAME_SCHED_TIMEOUT_EN.
module tx_frame_sched #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FRAME_WORDS    = 32,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  pilot_start,
  input  logic                  pilot_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  short_frame,
  output logic                  pilot_err
);

  localparam int unsigned WcW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned GcW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [WcW-1:0] LastWord  = WcW'(FRAME_WORDS - 1);
  // A zero guard length still spends one cycle in the guard state.
  localparam logic [GcW-1:0] GuardLast = GcW'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPilot, StData, StGuard} state_e;

  state_e               state_q, state_d;
  logic [WcW-1:0]       word_cnt_q, word_cnt_d;
  logic [GcW-1:0]       guard_cnt_q, guard_cnt_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                 pilot_start_q, pilot_start_d;
  logic                 short_frame_q, short_frame_d;
  logic                 in_data, xfer, last_word, pilot_to;

  assign in_data   = (state_q == StData);
  assign xfer      = in_data & s_axis_tvalid & m_axis_tready;
  assign last_word = (word_cnt_q == LastWord) | s_axis_tlast;

`ifdef TX_FRAME_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_cnt_q;
  logic           pilot_err_q;

  // pilot_done on the final allowed cycle still wins over the timeout.
  assign pilot_to = (state_q == StPilot) & ~pilot_done & (to_cnt_q == ToLast);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      to_cnt_q    <= '0;
      pilot_err_q <= 1'b0;
    end else begin
      if (state_q != StPilot) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != ToLast) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (pilot_to) begin
        pilot_err_q <= 1'b1;
      end
    end
  end

  assign pilot_err = pilot_err_q;
`else
  assign pilot_to  = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  assign pilot_err = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    pilot_start_d = 1'b0;
    short_frame_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && s_axis_tvalid) begin
          state_d       = StPilot;
          pilot_start_d = 1'b1;
        end
      end
      StPilot: begin
        if (pilot_done) begin
          state_d = StData;
        end else if (pilot_to) begin
          state_d     = StGuard;
          guard_cnt_d = '0;
        end
      end
      StData: begin
        if (xfer) begin
          if (last_word) begin
            word_cnt_d    = '0;
            guard_cnt_d   = '0;
            state_d       = StGuard;
            frame_cnt_d   = frame_cnt_q + 1'b1;
            short_frame_d = s_axis_tlast & (word_cnt_q != LastWord);
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      StGuard: begin
        if (guard_cnt_q == GuardLast) begin
          state_d = StIdle;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= StIdle;
      word_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      frame_cnt_q   <= '0;
      pilot_start_q <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      pilot_start_q <= pilot_start_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign s_axis_tready = in_data & m_axis_tready;
  assign m_axis_tvalid = in_data & s_axis_tvalid;
  assign m_axis_tdata  = in_data ? s_axis_tdata : '0;
  assign m_axis_tlast  = in_data & last_word;
  assign pilot_start   = pilot_start_q;
  assign short_frame   = short_frame_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the AXI-stream data width.
REQ-002 SHALL have parameter FRAME_WORDS, default 32, the number of data words per frame.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16, the idle cycles after each frame.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, the width of frame_cnt.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, the pilot watchdog limit (used only with the macro).
REQ-006 SHALL have port clk, input, 1 bit; the single clock; all logic is rising-edge.
REQ-007 SHALL have port arst, input, 1 bit; asynchronous, active-high reset.
REQ-008 SHALL have port enable, input, 1 bit; permits new frames to start.
REQ-009 SHALL have ports s_axis_tdata (input, DATA_WIDTH), s_axis_tvalid (input, 1), s_axis_tready (output, 1) and s_axis_tlast (input, 1); the upstream FIFO stream.
REQ-010 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1); the stream to the sender datapath.
REQ-011 SHALL have port pilot_start, output, 1 bit; requests insertion of the pilot/head sequence.
REQ-012 SHALL have port pilot_done, input, 1 bit; single-cycle pulse when the pilot has finished.
REQ-013 SHALL have ports busy (output, 1), frame_cnt (output, CNT_WIDTH), short_frame (output, 1) and pilot_err (output, 1).

Function
REQ-014 SHALL implement states IDLE, PILOT, DATA and GUARD.
REQ-015 In IDLE with enable=1 and s_axis_tvalid=1, SHALL enter PILOT and pulse pilot_start for exactly one cycle, on the first PILOT cycle.
REQ-016 In PILOT, SHALL wait for pilot_done=1, then enter DATA on the next cycle; pilot_done outside PILOT is ignored.
REQ-017 In DATA, SHALL pass data combinationally with zero latency: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
REQ-018 Outside DATA, s_axis_tready and m_axis_tvalid SHALL be 0; m_axis_tdata is don't-care.
REQ-019 SHALL count a word only when a transfer occurs (tvalid and tready both 1); the word counter runs 0..FRAME_WORDS-1.
REQ-020 m_axis_tlast SHALL be 1 in DATA when word_cnt=FRAME_WORDS-1 or s_axis_tlast=1.
REQ-021 On transfer of the tlast word, SHALL clear word_cnt, enter GUARD and increment frame_cnt (wraps modulo 2^CNT_WIDTH).
REQ-022 If the frame ends on s_axis_tlast with word_cnt<FRAME_WORDS-1, SHALL pulse short_frame for one cycle, coincident with the frame_cnt increment.
REQ-023 In GUARD, SHALL stay exactly GUARD_CYCLES cycles, then enter IDLE; GUARD_CYCLES=0 means one cycle of GUARD.
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; it blocks only the next IDLE-to-PILOT transition.
REQ-025 Upstream stalls (s_axis_tvalid=0) in DATA SHALL hold state and word_cnt indefinitely.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 On arst=1, SHALL immediately enter IDLE with word_cnt, frame_cnt and the guard/timeout counters set to 0, and pilot_start, short_frame, pilot_err, busy and m_axis_tlast set to 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without incrementing frame_cnt.

Configuration
REQ-029 With macro TX_FRAME_SCHED_TIMEOUT_EN defined, SHALL enter GUARD and set pilot_err if PILOT lasts TIMEOUT_CYCLES cycles without pilot_done; frame_cnt is not incremented and pilot_err stays set until reset.
REQ-030 Without TX_FRAME_SCHED_TIMEOUT_EN, PILOT SHALL wait indefinitely, pilot_err SHALL be tied to 0, and no timeout counter SHALL exist.

Verification
REQ-031 Full frame: enable=1, 32 back-to-back words 0x12345670+i, pilot_done 3 cycles after pilot_start -> exactly 32 transfers, m_axis_tlast on word 31, frame_cnt=1, then 16 GUARD cycles.
REQ-032 Short frame: s_axis_tlast on word 9 -> 10 transfers, tlast on word 9, short_frame pulsed once, frame_cnt=1.
REQ-033 Backpressure: m_axis_tready toggling every cycle -> 32 transfers with no lost or duplicated data, and s_axis_tready mirrors m_axis_tready in DATA.
REQ-034 Reset mid-DATA: arst asserted after word 12 -> IDLE, frame_cnt=0, and the next frame starts with a new pilot_start.
REQ-035 enable dropped during word 5 -> frame completes to 32 words, then stays in IDLE with no pilot_start until enable=1.
REQ-036 With TX_FRAME_SCHED_TIMEOUT_EN and pilot_done never asserted -> pilot_err=1 after 255 PILOT cycles, GUARD entered, frame_cnt=0.
